// File: rtl/mcc_run_pkg.sv
// Shared types and constants for the run controller: FSM encoding and timestamp width.
package mcc_run_pkg;

  localparam int TS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } run_state_t;

  // Down-counter load value for a phase lasting n cycles (n >= 1).
  function automatic logic [31:0] tmr_load(input int n);
    return 32'(n - 1);
  endfunction

endpackage

// File: rtl/mcc_run_ctrl_if.sv
// Handshake/data bundle between the run controller and its environment.
interface mcc_run_ctrl_if
  import mcc_run_pkg::*;
#(
  parameter int DATA_W = 24
);
  logic              start;
  logic [DATA_W-1:0] programOutput;
  logic              coreReset;
  logic              running;
  logic              done;
  logic [31:0]       cycleCount;
  logic [DATA_W-1:0] capData;
  logic [TS_W-1:0]   capTime;
  logic              capValid;
  logic              capReady;
  logic              capOverflow;

  modport slave (
    input  start, programOutput, capReady,
    output coreReset, running, done, cycleCount,
           capData, capTime, capValid, capOverflow
  );

  modport master (
    output start, programOutput, capReady,
    input  coreReset, running, done, cycleCount,
           capData, capTime, capValid, capOverflow
  );
endinterface

// File: rtl/mcc_cap_fifo.sv
// Capture FIFO with a registered head entry, so the output only moves on a pop
// or on a push into an empty FIFO. A push while full succeeds only alongside a pop.
module mcc_cap_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_do_pop;
  logic             w_do_push;
  logic [PW-1:0]    w_rd_next;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;
  assign w_rd_next = r_rd_ptr + 1'b1;
  assign o_dout    = r_head;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= w_rd_next;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // With one entry left, the next head can only come from a same-cycle push.
      if (w_do_pop) begin
        if (r_count != (PW+1)'(1)) r_head <= r_mem[w_rd_next];
        else if (w_do_push)        r_head <= i_din;
      end else if (w_do_push && o_empty) begin
        r_head <= i_din;
      end
    end
  end

endmodule

// File: rtl/mcc_run_ctrl.sv
// Reset/run sequencer for a controlled core, capturing changes of its output bus into a FIFO.
// Optional macro MCC_RUN_CTRL_TIMESTAMP_EN stores cycleCount[15:0] with each capture.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | core held in reset, waiting for start
//   RESET_HOLD  | core held in reset for RESET_CYCLES, FIFO/counters cleared
//   RUN         | core released, cycles counted, output changes captured
//   DONE        | core keeps running, counting and capture stopped
module mcc_run_ctrl
  import mcc_run_pkg::*;
#(
  parameter int DATA_W       = 24,
  parameter int RESET_CYCLES = 4,
  parameter int RUN_CYCLES   = 401,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic          mainClock,
  input  logic          reset,
  mcc_run_ctrl_if.slave bus
);

`ifdef MCC_RUN_CTRL_TIMESTAMP_EN
  localparam int FIFO_W = DATA_W + TS_W;
`else
  localparam int FIFO_W = DATA_W;
`endif

  run_state_t        r_state;
  logic [31:0]       r_tmr;
  logic [31:0]       r_cycle_cnt;
  logic [DATA_W-1:0] r_last;
  logic              r_overflow;
  logic              r_core_reset;
  logic              r_running;
  logic              r_done;

  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_W-1:0] w_fifo_din;
  logic [FIFO_W-1:0] w_fifo_dout;

  assign w_push  = (r_state == ST_RUN) && (bus.programOutput != r_last);
  assign w_pop   = bus.capReady && !w_empty;
  assign w_flush = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_tmr        <= '0;
      r_cycle_cnt  <= '0;
      r_last       <= '0;
      r_overflow   <= 1'b0;
      r_core_reset <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state      <= ST_RESET_HOLD;
            r_tmr        <= tmr_load(RESET_CYCLES);
            r_cycle_cnt  <= '0;
            r_last       <= '0;
            r_overflow   <= 1'b0;
            r_core_reset <= 1'b1;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
          end
        end
        ST_RESET_HOLD: begin
          if (r_tmr == '0) begin
            r_state      <= ST_RUN;
            r_tmr        <= tmr_load(RUN_CYCLES);
            r_core_reset <= 1'b0;
            r_running    <= 1'b1;
          end else begin
            r_tmr <= r_tmr - 32'd1;
          end
        end
        ST_RUN: begin
          r_cycle_cnt <= r_cycle_cnt + 32'd1;
          // The last-value register tracks the bus even when the push is dropped.
          if (w_push) r_last <= bus.programOutput;
          if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
          if (r_tmr == '0) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_tmr <= r_tmr - 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MCC_RUN_CTRL_TIMESTAMP_EN
  assign w_fifo_din  = {r_cycle_cnt[TS_W-1:0], bus.programOutput};
  assign bus.capTime = w_fifo_dout[FIFO_W-1:DATA_W];
`else
  assign w_fifo_din  = bus.programOutput;
  assign bus.capTime = '0;
`endif

  mcc_cap_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (mainClock),
    .rst_n   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (bus.capReady),
    .i_din   (w_fifo_din),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.coreReset   = r_core_reset;
  assign bus.running     = r_running;
  assign bus.done        = r_done;
  assign bus.cycleCount  = r_cycle_cnt;
  assign bus.capData     = w_fifo_dout[DATA_W-1:0];
  assign bus.capValid    = !w_empty;
  assign bus.capOverflow = r_overflow;

endmodule

// File: tb/tb_mcc_run_ctrl.sv
// Directed plus random-data bench for mcc_run_ctrl, checked against a queue-based capture model.
module tb_mcc_run_ctrl;
  localparam int DW    = 24;
  localparam int RST_C = 4;
  localparam int RUN_C = 401;
  localparam int DEPTH = 8;

  typedef struct {
    logic [DW-1:0] d;
    logic [15:0]   ts;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_err = 0;
  int   n_chk = 0;

  ent_t          q[$];
  logic [DW-1:0] m_last;
  bit            m_ovf;
  logic [DW-1:0] log_q[$];

  mcc_run_ctrl_if #(.DATA_W(DW)) bus_if ();

  mcc_run_ctrl #(
    .DATA_W       (DW),
    .RESET_CYCLES (RST_C),
    .RUN_CYCLES   (RUN_C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .mainClock (clk),
    .reset     (rst_n),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_ts(input logic [15:0] ts);
`ifdef MCC_RUN_CTRL_TIMESTAMP_EN
    return ts;
`else
    return 16'd0 & ts;
`endif
  endfunction

  task automatic model_clear();
    q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
  endtask

  // One clock with the given bus value and consumer ready; the model follows the capture rules.
  task automatic step(input int idx, input logic [DW-1:0] d, input bit rdy, input bit in_run);
    bit pop, full;
    bus_if.programOutput = d;
    bus_if.capReady      = rdy;
    cyc();
    pop  = rdy && (q.size() > 0);
    full = (q.size() == DEPTH);
    if (pop) q.delete(0);
    if (in_run && d != m_last) begin
      if (!full || pop) q.push_back('{d, 16'(idx)});
      else m_ovf = 1'b1;
      m_last = d;
    end
  endtask

  task automatic chk_fifo(input string tag);
    chk({tag, "_valid"}, 64'(bus_if.capValid), 64'(q.size() != 0));
    chk({tag, "_ovf"}, 64'(bus_if.capOverflow), 64'(m_ovf));
    if (q.size() != 0) begin
      chk({tag, "_data"}, 64'(bus_if.capData), 64'(q[0].d));
      chk({tag, "_time"}, 64'(bus_if.capTime), 64'(exp_ts(q[0].ts)));
    end
  endtask

  // Called at the sample just after start was taken; ends at the first RUN sample.
  task automatic hold_phase(input string tag);
    for (int i = 0; i < RST_C; i++) begin
      chk($sformatf("%s_hold%0d_corereset", tag, i), 64'(bus_if.coreReset), 64'd1);
      chk($sformatf("%s_hold%0d_running", tag, i), 64'(bus_if.running), 64'd0);
      bus_if.start = (i == 1);
      cyc();
    end
    bus_if.start = 1'b0;
    chk({tag, "_run_entry_running"}, 64'(bus_if.running), 64'd1);
    chk({tag, "_run_entry_corereset"}, 64'(bus_if.coreReset), 64'd0);
    chk({tag, "_run_entry_count"}, 64'(bus_if.cycleCount), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] seq_a [7];
    logic [DW-1:0] d;
    bit            r;
    seq_a = '{24'd0, 24'd5, 24'd5, 24'd9, 24'd9, 24'd3, 24'd3};

    rst_n                = 1'b0;
    bus_if.start         = 1'b0;
    bus_if.programOutput = '0;
    bus_if.capReady      = 1'b0;
    model_clear();
    cyc(); cyc();
    chk("rst_corereset", 64'(bus_if.coreReset), 64'd1);
    chk("rst_running", 64'(bus_if.running), 64'd0);
    chk("rst_done", 64'(bus_if.done), 64'd0);
    chk("rst_capvalid", 64'(bus_if.capValid), 64'd0);
    chk("rst_ovf", 64'(bus_if.capOverflow), 64'd0);
    chk("rst_count", 64'(bus_if.cycleCount), 64'd0);
    chk("rst_capdata", 64'(bus_if.capData), 64'd0);
    chk("rst_captime", 64'(bus_if.capTime), 64'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    chk("idle_corereset", 64'(bus_if.coreReset), 64'd1);
    chk("idle_running", 64'(bus_if.running), 64'd0);

    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    hold_phase("r1");

    for (int i = 0; i < RUN_C; i++) begin
      chk($sformatf("r1_c%0d_running", i), 64'(bus_if.running), 64'd1);
      chk($sformatf("r1_c%0d_count", i), 64'(bus_if.cycleCount), 64'(i));
      if (i <= 6)       begin d = seq_a[i];              r = 1'b1; end
      else if (i == 7)  begin d = 24'h77;                r = 1'b0; end
      else if (i == 8)  begin d = 24'h77;                r = 1'b1; end
      else if (i <= 16) begin d = 24'(32'h100 + i - 9);  r = 1'b0; end
      else if (i == 17) begin d = 24'h108;               r = 1'b1; end
      else if (i <= 19) begin d = 24'(32'h109 + i - 18); r = 1'b0; end
      else if (i <= 27) begin d = 24'h10A;               r = 1'b1; end
      else begin
        d = 24'($urandom_range(0, 3));
        r = 1'($urandom_range(0, 1));
        bus_if.start = 1'($urandom_range(0, 1));
      end
      if (r && bus_if.capValid && (i <= 6 || (i >= 20 && i <= 27))) log_q.push_back(bus_if.capData);
      step(i, d, r, 1'b1);
      chk_fifo($sformatf("r1_c%0d", i));
      if (i == 6) begin
        chk("seqA_len", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
          chk("seqA_0", 64'(log_q[0]), 64'd5);
          chk("seqA_1", 64'(log_q[1]), 64'd9);
          chk("seqA_2", 64'(log_q[2]), 64'd3);
        end
        log_q.delete();
      end
`ifdef MCC_RUN_CTRL_TIMESTAMP_EN
      if (i == 7) chk("ts_cycle7", 64'(bus_if.capTime), 64'd7);
`else
      if (i == 7) chk("ts_off_cycle7", 64'(bus_if.capTime), 64'd0);
`endif
      if (i == 17) chk("full_pushpop_ovf", 64'(bus_if.capOverflow), 64'd0);
      if (i == 18) chk("full_drop_ovf", 64'(bus_if.capOverflow), 64'd1);
      if (i == 27) begin
        chk("drain_len", 64'(log_q.size()), 64'd8);
        for (int k = 0; k < 8 && k < log_q.size(); k++)
          chk($sformatf("drain_%0d", k), 64'(log_q[k]), 64'(32'h101 + k));
        chk("drain_empty", 64'(bus_if.capValid), 64'd0);
      end
    end
    bus_if.start = 1'b0;

    chk("done_flag", 64'(bus_if.done), 64'd1);
    chk("done_running", 64'(bus_if.running), 64'd0);
    chk("done_corereset", 64'(bus_if.coreReset), 64'd0);
    chk("done_count", 64'(bus_if.cycleCount), 64'(RUN_C));
    for (int i = 0; i < 5; i++) begin
      step(RUN_C + i, 24'(32'h300 + i), 1'($urandom_range(0, 1)), 1'b0);
      chk($sformatf("done%0d_count", i), 64'(bus_if.cycleCount), 64'(RUN_C));
      chk($sformatf("done%0d_flag", i), 64'(bus_if.done), 64'd1);
      chk_fifo($sformatf("done%0d", i));
    end

    // Second sequence: overflow from a clean state, then a mid-run reset.
    bus_if.capReady = 1'b0;
    bus_if.start    = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    model_clear();
    chk("restart_flush", 64'(bus_if.capValid), 64'd0);
    chk("restart_ovf", 64'(bus_if.capOverflow), 64'd0);
    chk("restart_count", 64'(bus_if.cycleCount), 64'd0);
    chk("restart_done", 64'(bus_if.done), 64'd0);
    hold_phase("r2");
    for (int i = 0; i < 50; i++) begin
      d = (i < 10) ? 24'(32'h201 + i) : 24'h20A;
      step(i, d, 1'b0, 1'b1);
      chk_fifo($sformatf("r2_c%0d", i));
      if (i == 7) chk("ovf10_before", 64'(bus_if.capOverflow), 64'd0);
      if (i == 8) chk("ovf10_set", 64'(bus_if.capOverflow), 64'd1);
    end
    chk("ovf10_head", 64'(bus_if.capData), 64'h201);
    chk("mid_count50", 64'(bus_if.cycleCount), 64'd50);
    chk("mid_valid_before", 64'(bus_if.capValid), 64'd1);

    rst_n = 1'b0;
    #1;
    model_clear();
    chk("abort_corereset", 64'(bus_if.coreReset), 64'd1);
    chk("abort_running", 64'(bus_if.running), 64'd0);
    chk("abort_valid", 64'(bus_if.capValid), 64'd0);
    chk("abort_ovf", 64'(bus_if.capOverflow), 64'd0);
    chk("abort_count", 64'(bus_if.cycleCount), 64'd0);
    chk("abort_capdata", 64'(bus_if.capData), 64'd0);
    cyc(); cyc();

    rst_n        = 1'b1;
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    hold_phase("r3");
    for (int i = 0; i < 20; i++) begin
      step(i, 24'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1);
      chk($sformatf("r3_c%0d_count", i), 64'(bus_if.cycleCount), 64'(i + 1));
      chk_fifo($sformatf("r3_c%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mcc_run_ctrl.md
MCC_RUN_CTRL -- requirements
Module: mcc_run_ctrl

Interface
REQ-001 Parameter DATA_W, default 24: width of observed programOutput and captured data.
REQ-002 Parameter RESET_CYCLES, default 4: cycles coreReset is held asserted before run; legal range is 1 or more.
REQ-003 Parameter RUN_CYCLES, default 401: cycles core runs before done; legal range is 1 or more.
REQ-004 Parameter FIFO_DEPTH, default 8: capture FIFO entries; must be a power of two, 2 or more.
REQ-005 mainClock  in  1  sole clock, rising-edge.
REQ-006 reset  in  1  asynchronous, active-low block reset.
REQ-007 start  in  1  single-cycle request to begin a reset/run sequence.
REQ-008 programOutput  in  DATA_W  output bus of the core under control.
REQ-009 coreReset  out  1  active-high reset driven to the core.
REQ-010 running  out  1  high while in RUN.
REQ-011 done  out  1  high while in DONE.
REQ-012 cycleCount  out  32  RUN cycles elapsed in current sequence.
REQ-013 capData  out  DATA_W  head FIFO entry.
REQ-014 capTime  out  16  head entry timestamp; see REQ-030.
REQ-015 capValid  out  1  FIFO non-empty.
REQ-016 capReady  in  1  consumer pop; a pop occurs on any cycle with capValid and capReady both high.
REQ-017 capOverflow  out  1  sticky; a capture was dropped.

Function
REQ-018 FSM states and transitions:
- IDLE -> RESET_HOLD on start.
- RESET_HOLD -> RUN after exactly RESET_CYCLES cycles in RESET_HOLD.
- RUN -> DONE after exactly RUN_CYCLES cycles in RUN.
- DONE -> RESET_HOLD on start.
REQ-019 Outputs by state:
- coreReset is 1 in IDLE and RESET_HOLD, 0 in RUN and DONE.
- DONE holds the core running; the block only stops capturing.
REQ-020 start is ignored in RESET_HOLD and RUN.
REQ-021 Entry to RESET_HOLD performs all of the following:
- clears cycleCount, capOverflow and the last-value register to 0;
- flushes the FIFO.
REQ-022 cycleCount increments once per RUN cycle, reaches RUN_CYCLES on entry to DONE, and then holds.
REQ-023 Capture rule: in each RUN cycle, if programOutput differs from the last-value register, the block pushes programOutput and updates the register in the same cycle.
REQ-024 A push while the FIFO is full is dropped and sets capOverflow; a push and a pop in the same cycle while full both succeed.
REQ-025 Pop while empty has no effect.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-027 capData and capTime are valid whenever capValid is high, and they change only on a pop or a push into an empty FIFO.

Reset
REQ-028 While reset is low, the block is in the following state:
- FSM in IDLE;
- coreReset=1; running, done, capValid and capOverflow = 0;
- cycleCount=0; capData=0; capTime=0;
- FIFO empty.
Reset asserted mid-sequence aborts immediately with the same values.
REQ-029 On the first edge after reset deasserts, the block is in IDLE and acts on start.

Configuration
REQ-030 Macro MCC_RUN_CTRL_TIMESTAMP_EN:
- Defined: each FIFO entry also stores cycleCount[15:0] at push time, presented on capTime.
- Undefined: no timestamp storage; capTime is tied to 0.

Structure
REQ-031 Package mcc_run_pkg holds the FSM state encoding and the 16-bit timestamp width constant.
REQ-032 The capture FIFO is sub-module mcc_cap_fifo, parametrised by width and depth, with push/pop/full/empty ports.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Default params, start pulse at cycle 10 -> coreReset high for 4 cycles, then running for 401 cycles, then done=1 with cycleCount=401.
- programOutput stepped 0,5,5,9,9,3 during RUN with capReady=1 -> capData sequence 5,9,3; no capture for repeated values.
- capReady=0, 10 distinct values with depth 8 -> 8 entries retained in order; capOverflow=1; 9th and 10th dropped.
- FIFO full, simultaneous new value and capReady=1 -> pop and push both occur; count stays 8; capOverflow stays 0.
- reset driven low at cycle 50 of RUN -> immediate IDLE, coreReset=1, FIFO empty, cycleCount=0.
- With MCC_RUN_CTRL_TIMESTAMP_EN, change at RUN cycle 7 -> capTime=7; without the macro -> capTime=0.
